// File: rtl/xfer_done_monitor.sv
// rtl/xfer_done_monitor.sv - TX/RX beat-count transfer monitor producing send_done/recv_done/timeout pulses
module xfer_done_monitor #(
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 125000000,
  parameter int          TO_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_tx_beats,
  input  logic [CNT_W-1:0] cfg_rx_beats,
  input  logic             tx_valid,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic             rx_ready,
  output logic             send_done,
  output logic             recv_done,
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;

  // Last RECV cycle index before the timeout pulse fires.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] tgt_tx_q, tgt_tx_d;
  logic [CNT_W-1:0] tgt_rx_q, tgt_rx_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             send_done_q, send_done_d;
  logic             recv_done_q, recv_done_d;
  logic             timeout_q, timeout_d;
  logic             busy_q, busy_d;

  logic             tx_hs;
  logic             rx_hs;
  logic [CNT_W-1:0] tx_cnt_inc;
  logic [CNT_W-1:0] rx_cnt_inc;

  assign tx_hs = tx_valid & tx_ready;
  assign rx_hs = rx_valid & rx_ready;

  // Saturating next counts: beats past the target are dropped so counters never wrap.
  always_comb begin
    tx_cnt_inc = tx_cnt_q;
    rx_cnt_inc = rx_cnt_q;
    if (tx_hs && (tx_cnt_q < tgt_tx_q)) begin
      tx_cnt_inc = tx_cnt_q + 1'b1;
    end
    if (rx_hs && (rx_cnt_q < tgt_rx_q)) begin
      rx_cnt_inc = rx_cnt_q + 1'b1;
    end
  end

  // Phase sequencing; every output is a register so pulses are glitch-free and one cycle wide.
  always_comb begin
    state_d     = state_q;
    tgt_tx_d    = tgt_tx_q;
    tgt_rx_d    = tgt_rx_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    to_cnt_d    = to_cnt_q;
    busy_d      = busy_q;
    send_done_d = 1'b0;
    recv_done_d = 1'b0;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tgt_tx_d = cfg_tx_beats;
          tgt_rx_d = cfg_rx_beats;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          to_cnt_d = '0;
          busy_d   = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_cnt_d = tx_cnt_inc;
        rx_cnt_d = rx_cnt_inc;
        if (tx_cnt_inc == tgt_tx_q) begin
          send_done_d = 1'b1;
          state_d     = ST_RECV;
        end
      end
      ST_RECV: begin
        rx_cnt_d = rx_cnt_inc;
        to_cnt_d = to_cnt_q + 1'b1;
        // Completion takes priority over a timeout landing on the same cycle.
        if (rx_cnt_inc >= tgt_rx_q) begin
          recv_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tgt_tx_q    <= '0;
      tgt_rx_q    <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      to_cnt_q    <= '0;
      send_done_q <= 1'b0;
      recv_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_tx_q    <= tgt_tx_d;
      tgt_rx_q    <= tgt_rx_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      send_done_q <= send_done_d;
      recv_done_q <= recv_done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
    end
  end

  assign send_done = send_done_q;
  assign recv_done = recv_done_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign tx_cnt    = tx_cnt_q;
  assign rx_cnt    = rx_cnt_q;

endmodule

// File: tb/tb_xfer_done_monitor.sv
// tb/tb_xfer_done_monitor.sv - scoreboard bench for xfer_done_monitor
module tb_xfer_done_monitor;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_tx_beats = '0;
  logic [31:0] cfg_rx_beats = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready = 1'b0;
  logic        send_done;
  logic        recv_done;
  logic        timeout;
  logic        busy;
  logic [31:0] tx_cnt;
  logic [31:0] rx_cnt;

  xfer_done_monitor #(.CNT_W(32), .TIMEOUT_CYC(TO), .TO_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_tx_beats(cfg_tx_beats), .cfg_rx_beats(cfg_rx_beats),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .send_done(send_done), .recv_done(recv_done), .timeout(timeout), .busy(busy),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // kind: 1 = send_done, 2 = recv_done, 4 = timeout
  typedef struct {
    int kind;
    int cyc;
    int tx;
    int rx;
  } ev_t;
  ev_t exp_q[$];

  // Transfer-level reference: beats seen since start and cycle of RECV entry.
  int  m_stage = 0;
  int  m_tgt_tx = 0;
  int  m_tgt_rx = 0;
  int  m_tx_seen = 0;
  int  m_rx_seen = 0;
  int  m_recv_entry = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  int  exp_busy = 0;
  int  exp_tx = 0;
  int  exp_rx = 0;

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic push_ev(int kind, int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.tx   = imin(m_tx_seen, m_tgt_tx);
    e.rx   = imin(m_rx_seen, m_tgt_rx);
    exp_q.push_back(e);
  endtask

  // Called just after a clock edge with the inputs that edge sampled; predicts the cycle that follows.
  task automatic model_step();
    int k;
    int txh;
    int rxh;
    k   = cyc;
    cyc = k + 1;
    txh = (tx_valid && tx_ready) ? 1 : 0;
    rxh = (rx_valid && rx_ready) ? 1 : 0;
    if (!rst_n) begin
      m_stage = 0; m_tgt_tx = 0; m_tgt_rx = 0; m_tx_seen = 0; m_rx_seen = 0;
    end else if (m_stage == 0) begin
      if (start) begin
        m_stage = 1;
        m_tgt_tx = int'(cfg_tx_beats);
        m_tgt_rx = int'(cfg_rx_beats);
        m_tx_seen = 0;
        m_rx_seen = 0;
      end
    end else if (m_stage == 1) begin
      m_tx_seen += txh;
      m_rx_seen += rxh;
      if (m_tx_seen >= m_tgt_tx) begin
        push_ev(1, k + 1);
        m_stage = 2;
        m_recv_entry = k + 1;
      end
    end else begin
      m_rx_seen += rxh;
      if (m_rx_seen >= m_tgt_rx) begin
        push_ev(2, k + 1);
        m_stage = 0;
      end else if (k == m_recv_entry + TO - 1) begin
        push_ev(4, k + 1);
        m_stage = 0;
      end
    end
    exp_busy = (m_stage != 0) ? 1 : 0;
    exp_tx   = imin(m_tx_seen, m_tgt_tx);
    exp_rx   = imin(m_rx_seen, m_tgt_rx);
  endtask

  task automatic check(string name, int act, int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    mon_en = 1'b1;
    #1;
  endtask

  task automatic set_in(bit s, bit txh, bit rxh);
    int r;
    start = s;
    r = $urandom_range(0, 2);
    tx_valid = txh || (r == 1);
    tx_ready = txh || (r == 2);
    r = $urandom_range(0, 2);
    rx_valid = rxh || (r == 1);
    rx_ready = rxh || (r == 2);
  endtask

  task automatic cyc1(bit s, bit txh, bit rxh);
    set_in(s, txh, rxh);
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc1(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard whenever a pulse is presented.
  always @(negedge clk) begin
    if (mon_en) begin
      int pulses;
      ev_t e;
      n_tests++;
      if (busy !== exp_busy[0] || int'(tx_cnt) !== exp_tx || int'(rx_cnt) !== exp_rx) begin
        n_fail++;
        $display("FAIL status: got busy=%0b tx=%0d rx=%0d expected busy=%0d tx=%0d rx=%0d (cycle %0d)",
                 busy, tx_cnt, rx_cnt, exp_busy, exp_tx, exp_rx, cyc);
      end
      pulses = {29'd0, timeout, recv_done, send_done};
      if (pulses != 0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: got pulses=%0d expected none (cycle %0d)", pulses, cyc);
        end else begin
          e = exp_q.pop_front();
          if (pulses != e.kind || e.cyc != cyc || int'(tx_cnt) != e.tx || int'(rx_cnt) != e.rx) begin
            n_fail++;
            $display("FAIL pulse: got kind=%0d cyc=%0d tx=%0d rx=%0d expected kind=%0d cyc=%0d tx=%0d rx=%0d",
                     pulses, cyc, tx_cnt, rx_cnt, e.kind, e.cyc, e.tx, e.rx);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        n_tests++;
        n_fail++;
        e = exp_q.pop_front();
        $display("FAIL missed_pulse: got none expected kind=%0d at cycle %0d", e.kind, e.cyc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // 1: 4 TX beats, RX 10 cycles later
    cfg_tx_beats = 4; cfg_rx_beats = 2;
    cyc1(1, 0, 0);
    cyc1(0, 1, 0); cyc1(0, 0, 0); cyc1(0, 1, 0); cyc1(0, 1, 0); cyc1(0, 1, 0);
    idle(10);
    cyc1(0, 0, 1); cyc1(0, 0, 1);
    idle(3);
    check("t1_tx_cnt", int'(tx_cnt), 4);
    check("t1_rx_cnt", int'(rx_cnt), 2);

    // 2: RX leads TX
    cfg_tx_beats = 3; cfg_rx_beats = 3;
    cyc1(1, 0, 0);
    cyc1(0, 1, 1); cyc1(0, 0, 1); cyc1(0, 0, 1); cyc1(0, 1, 0); cyc1(0, 1, 0);
    idle(3);

    // 3: zero targets
    cfg_tx_beats = 0; cfg_rx_beats = 0;
    cyc1(1, 0, 0);
    idle(4);
    check("t3_busy", int'(busy), 0);

    // 4: timeout with only 2 of 5 RX beats
    cfg_tx_beats = 1; cfg_rx_beats = 5;
    cyc1(1, 0, 0);
    cyc1(0, 1, 0);
    cyc1(0, 0, 1); cyc1(0, 0, 1);
    idle(20);
    check("t4_rx_cnt", int'(rx_cnt), 2);

    // 5: start while busy, extra TX beats
    cfg_tx_beats = 4; cfg_rx_beats = 1;
    cyc1(1, 0, 0);
    for (int i = 0; i < 6; i++) cyc1(1, 1, 0);
    cyc1(0, 0, 1);
    idle(3);
    check("t5_tx_cnt", int'(tx_cnt), 4);

    // 6: reset in RECV with RX pending
    cfg_tx_beats = 2; cfg_rx_beats = 5;
    cyc1(1, 0, 0);
    cyc1(0, 1, 0); cyc1(0, 1, 1);
    rst_n = 1'b0;
    cyc1(0, 0, 0);
    rst_n = 1'b1;
    check("t6_busy", int'(busy), 0);
    check("t6_rx_cnt", int'(rx_cnt), 0);
    idle(25);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      cfg_tx_beats = $urandom_range(0, 6);
      cfg_rx_beats = $urandom_range(0, 6);
      rst_n = ($urandom_range(0, 299) != 0);
      cyc1(($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
    end
    rst_n = 1'b1;
    idle(30);
    check("pending_events", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
